tlb_entry_alloc: RTL and testbench

- Allocator for a fixed pool of TLB/refill-buffer entries, tracked in an ENTRIES-bit occupancy bitmap.
- Alloc side: a lowest-index-first priority search turns the free-bit vector into an index (one-hot to index).
- Free side: a returned index is decoded back to a one-hot clear mask (index to one-hot). This is the opposite conversion from the alloc side.
- Sits between the TLB refill/fill logic (consumer of indices) and the invalidate/retire path (returner of indices).

---
 rtl/tlb_entry_alloc_if.sv | 27 ++
 rtl/tlb_entry_alloc.sv | 83 ++++++++
 tb/tb_tlb_entry_alloc.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/tlb_entry_alloc_if.sv
// Request/return/status bundle between the TLB refill logic and the entry allocator.
interface tlb_entry_alloc_if #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
);
  logic               flush;
  logic               alloc_valid;
  logic               alloc_ready;
  logic [IDX_W-1:0]   alloc_idx;
  logic               free_valid;
  logic [IDX_W-1:0]   free_idx;
  logic [ENTRIES-1:0] occ;
  logic [IDX_W:0]     count;
  logic               full;
  logic               empty;
  logic               free_err;

  modport master (
    output flush, alloc_valid, free_valid, free_idx,
    input  alloc_ready, alloc_idx, occ, count, full, empty, free_err
  );

  modport slave (
    input  flush, alloc_valid, free_valid, free_idx,
    output alloc_ready, alloc_idx, occ, count, full, empty, free_err
  );
endinterface

// File: rtl/tlb_entry_alloc.sv
// Occupancy-bitmap allocator: lowest-free-first index on the alloc side,
// index-to-one-hot clear on the free side, with flush and double-free detection.
module tlb_entry_alloc #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input logic              clk,
  input logic              resetn,
  tlb_entry_alloc_if.slave bus
);

  logic [ENTRIES-1:0] occ_q, occ_d;
  logic [IDX_W:0]     count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               free_err_q, free_err_d;

  logic [IDX_W-1:0]   alloc_idx;
  logic               alloc_ready;
  logic               alloc_fire;
  logic               free_hit;
  logic               free_legal;
  logic               free_illegal;
  logic [ENTRIES-1:0] alloc_mask;
  logic [ENTRIES-1:0] free_mask;

  // Scan from the top down so the last assignment wins with the lowest free index.
  always_comb begin
    alloc_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!occ_q[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign alloc_ready  = ~full_q & ~bus.flush;
  assign alloc_fire   = bus.alloc_valid & alloc_ready;
  assign free_hit     = occ_q[bus.free_idx];
  assign free_legal   = bus.free_valid & ~bus.flush & free_hit;
  assign free_illegal = bus.free_valid & ~bus.flush & ~free_hit;

  assign alloc_mask = {{(ENTRIES-1){1'b0}}, alloc_fire} << alloc_idx;
  assign free_mask  = {{(ENTRIES-1){1'b0}}, free_legal} << bus.free_idx;

  // The alloc index is free pre-edge and a legal free index is occupied pre-edge,
  // so the two masks never overlap and can be applied together.
  always_comb begin
    occ_d      = (occ_q & ~free_mask) | alloc_mask;
    count_d    = count_q + {{IDX_W{1'b0}}, alloc_fire} - {{IDX_W{1'b0}}, free_legal};
    free_err_d = free_illegal;
    if (bus.flush) begin
      occ_d      = '0;
      count_d    = '0;
      free_err_d = 1'b0;
    end
    full_d  = (count_d == (IDX_W+1)'(ENTRIES));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      occ_q      <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      free_err_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      free_err_q <= free_err_d;
    end
  end

  assign bus.alloc_ready = alloc_ready;
  assign bus.alloc_idx   = alloc_idx;
  assign bus.occ         = occ_q;
  assign bus.count       = count_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.free_err    = free_err_q;

endmodule

// File: tb/tb_tlb_entry_alloc.sv
// Table-driven bench for tlb_entry_alloc: vectors check the pre-edge handshake,
// a scoreboard queue checks the registered state after each edge.
module tb_tlb_entry_alloc;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  typedef struct {
    logic        flush;
    logic        av;
    logic        fv;
    logic [3:0]  fidx;
    logic        expReady;
    logic [3:0]  expIdx;
    logic [15:0] expOcc;
    logic [4:0]  expCount;
    logic        expErr;
    int          id;
  } vec_t;

  logic clk;
  logic resetn;
  int   nChecks;
  int   nFail;
  int   nVec;
  vec_t vecs [0:79];
  vec_t sbQueue [$];

  tlb_entry_alloc_if #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) bus ();

  tlb_entry_alloc #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic fl, input logic av, input logic fv, input int fidx,
                        input logic eRdy, input int eIdx, input logic [31:0] eOcc,
                        input int eCnt, input logic eErr);
    vec_t v;
    v.flush    = fl;
    v.av       = av;
    v.fv       = fv;
    v.fidx     = 4'(fidx);
    v.expReady = eRdy;
    v.expIdx   = 4'(eIdx);
    v.expOcc   = eOcc[15:0];
    v.expCount = 5'(eCnt);
    v.expErr   = eErr;
    v.id       = nVec;
    vecs[nVec] = v;
    nVec++;
  endtask

  task automatic driveIdle();
    bus.flush       = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.free_valid  = 1'b0;
    bus.free_idx    = '0;
  endtask

  // Drive at the falling edge, check the combinational handshake, queue the post-edge state.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.flush       = v.flush;
    bus.alloc_valid = v.av;
    bus.free_valid  = v.fv;
    bus.free_idx    = v.fidx;
    #1;
    checkOutput($sformatf("v%0d alloc_ready", v.id), 32'(bus.alloc_ready), 32'(v.expReady));
    checkOutput($sformatf("v%0d alloc_idx", v.id), 32'(bus.alloc_idx), 32'(v.expIdx));
    sbQueue.push_back(v);
  endtask

  always @(posedge clk) begin
    #1;
    if (sbQueue.size() > 0) begin
      vec_t e;
      e = sbQueue.pop_front();
      checkOutput($sformatf("v%0d occ", e.id), 32'(bus.occ), 32'(e.expOcc));
      checkOutput($sformatf("v%0d count", e.id), 32'(bus.count), 32'(e.expCount));
      checkOutput($sformatf("v%0d full", e.id), 32'(bus.full), 32'(e.expCount == 5'd16));
      checkOutput($sformatf("v%0d empty", e.id), 32'(bus.empty), 32'(e.expCount == 5'd0));
      checkOutput($sformatf("v%0d free_err", e.id), 32'(bus.free_err), 32'(e.expErr));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    int   drain;
    nChecks = 0;
    nFail   = 0;
    nVec    = 0;

    // Fill to full, then free/alloc at full, then flush with everything asserted.
    for (int i = 0; i < 16; i++) addVec(0, 1, 0, 0, 1, i, (32'h1 << (i + 1)) - 1, i + 1, 0);
    addVec(0, 0, 0, 0, 0, 0, 32'hFFFF, 16, 0);
    addVec(0, 1, 1, 5, 0, 0, 32'hFFDF, 15, 0);
    addVec(0, 1, 0, 0, 1, 5, 32'hFFFF, 16, 0);
    addVec(1, 1, 1, 2, 0, 0, 32'h0000, 0, 0);
    // occ=000F, then alloc+free in the same cycle.
    for (int i = 0; i < 4; i++) addVec(0, 1, 0, 0, 1, i, (32'h1 << (i + 1)) - 1, i + 1, 0);
    addVec(0, 1, 1, 1, 1, 4, 32'h001D, 4, 0);
    addVec(1, 0, 0, 0, 0, 1, 32'h0000, 0, 0);
    // occ=0003, double free of entry 7.
    for (int i = 0; i < 2; i++) addVec(0, 1, 0, 0, 1, i, (32'h1 << (i + 1)) - 1, i + 1, 0);
    addVec(0, 0, 1, 7, 1, 2, 32'h0003, 2, 1);
    addVec(0, 0, 0, 0, 1, 2, 32'h0003, 2, 0);
    // occ=00FF, then flush overriding alloc and free; an illegal free under flush raises nothing.
    for (int i = 2; i < 8; i++) addVec(0, 1, 0, 0, 1, i, (32'h1 << (i + 1)) - 1, i + 1, 0);
    addVec(1, 1, 1, 2, 0, 8, 32'h0000, 0, 0);
    addVec(1, 0, 1, 3, 0, 0, 32'h0000, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 32'h0000, 0, 0);
    // Build occ=0F0F for the mid-stream reset.
    for (int i = 0; i < 12; i++) addVec(0, 1, 0, 0, 1, i, (32'h1 << (i + 1)) - 1, i + 1, 0);
    for (int k = 4; k < 8; k++)
      addVec(0, 0, 1, k, 1, (k == 4) ? 12 : 4,
             32'h0FFF & ~(((32'h1 << (k + 1)) - 1) ^ 32'hF), 12 - (k - 3), 0);

    driveIdle();
    resetn = 1'b0;
    #12;
    checkOutput("reset occ", 32'(bus.occ), 32'h0);
    checkOutput("reset count", 32'(bus.count), 32'h0);
    checkOutput("reset full", 32'(bus.full), 32'h0);
    checkOutput("reset empty", 32'(bus.empty), 32'h1);
    checkOutput("reset free_err", 32'(bus.free_err), 32'h0);
    checkOutput("reset alloc_ready", 32'(bus.alloc_ready), 32'h1);
    checkOutput("reset alloc_idx", 32'(bus.alloc_idx), 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < nVec; i++) applyStimulus(vecs[i]);

    @(negedge clk);
    driveIdle();
    checkOutput("pre-reset occ", 32'(bus.occ), 32'h0F0F);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("midreset occ", 32'(bus.occ), 32'h0);
    checkOutput("midreset count", 32'(bus.count), 32'h0);
    checkOutput("midreset empty", 32'(bus.empty), 32'h1);
    checkOutput("midreset full", 32'(bus.full), 32'h0);
    checkOutput("midreset free_err", 32'(bus.free_err), 32'h0);
    checkOutput("midreset alloc_idx", 32'(bus.alloc_idx), 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    v.flush = 0; v.av = 1; v.fv = 0; v.fidx = 0;
    v.expReady = 1; v.expIdx = 0; v.expOcc = 16'h0001; v.expCount = 5'd1; v.expErr = 0;
    v.id = 100;
    applyStimulus(v);
    @(negedge clk);
    driveIdle();

    drain = 0;
    while (sbQueue.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    if (sbQueue.size() > 0) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sbQueue.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
